// File: rtl/scad_pkg.sv
// Op codes, FSM states and the {M,S,CIN} control word shared by every slice of the SCAD ALU chain.
// encode_op maps an operation to that word; reserved codes fall back to PASSA.
package scad_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_INC   = 4'd2,
        OP_DEC   = 4'd3,
        OP_PASSA = 4'd4,
        OP_PASSB = 4'd5,
        OP_AND   = 4'd6,
        OP_OR    = 4'd7,
        OP_XOR   = 4'd8,
        OP_NOTA  = 4'd9,
        OP_ZERO  = 4'd10,
        OP_COUNT = 4'd11,
        OP_RSV12 = 4'd12,
        OP_RSV13 = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_COUNT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       m;
        logic [0:3] s;
        logic       cin;
    } alu_ctl_t;

    // Logic-mode ops drive CIN low since the slice ignores it there.
    function automatic alu_ctl_t encode_op(input alu_op_t op);
        alu_ctl_t c;
        c = '{m: 1'b1, s: 4'b1111, cin: 1'b0};
        case (op)
            OP_ADD:   c = '{m: 1'b0, s: 4'b0110, cin: 1'b0};
            OP_SUB:   c = '{m: 1'b0, s: 4'b1001, cin: 1'b1};
            OP_INC:   c = '{m: 1'b0, s: 4'b0000, cin: 1'b1};
            OP_DEC:   c = '{m: 1'b0, s: 4'b1111, cin: 1'b0};
            OP_COUNT: c = '{m: 1'b0, s: 4'b1111, cin: 1'b0};
            OP_PASSA: c = '{m: 1'b1, s: 4'b1111, cin: 1'b0};
            OP_PASSB: c = '{m: 1'b1, s: 4'b1010, cin: 1'b0};
            OP_AND:   c = '{m: 1'b1, s: 4'b1110, cin: 1'b0};
            OP_OR:    c = '{m: 1'b1, s: 4'b1011, cin: 1'b0};
            OP_XOR:   c = '{m: 1'b1, s: 4'b1001, cin: 1'b0};
            OP_NOTA:  c = '{m: 1'b1, s: 4'b0000, cin: 1'b0};
            OP_ZERO:  c = '{m: 1'b1, s: 4'b1100, cin: 1'b0};
            default:  c = '{m: 1'b1, s: 4'b1111, cin: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc10181.sv
// Behavioural MC10181 4-bit ALU slice, big-endian (bit 0 = MSB); purely combinational.
// Arithmetic mode computes A + Y + CIN, with S[0]/S[1] selecting ~B/B terms of Y.
module mc10181 (
    input  logic [0:3] a,
    input  logic [0:3] b,
    input  logic [0:3] s,
    input  logic       m,
    input  logic       cin,
    output logic [0:3] f,
    output logic       cout
);

    logic [0:3] y;
    logic [4:0] sum;

    always_comb begin
        y    = (b & {4{s[1]}}) | (~b & {4{s[0]}});
        sum  = {1'b0, a} + {1'b0, y} + {4'b0000, cin};
        f    = sum[3:0];
        cout = sum[4];
        if (m) begin
            cout = 1'b0;
            case (s)
                4'b0000: f = ~a;
                4'b0001: f = ~(a & b);
                4'b0010: f = a | ~b;
                4'b0011: f = 4'b1111;
                4'b0100: f = ~(a | b);
                4'b0101: f = ~b;
                4'b0110: f = ~(a ^ b);
                4'b0111: f = ~a | b;
                4'b1000: f = ~a & b;
                4'b1001: f = a ^ b;
                4'b1010: f = b;
                4'b1011: f = a | b;
                4'b1100: f = 4'b0000;
                4'b1101: f = a & ~b;
                4'b1110: f = a & b;
                default: f = a;
            endcase
        end
    end

endmodule

// File: rtl/scad_alu_ctl.sv
// SCAD ALU controller: encodes ops onto a 3-slice mc10181 chain, registers results, runs COUNT loop.
// Result 2 clk after accept (COUNT: 2 + decrements); req_ready high only in IDLE.
module scad_alu_ctl
    import scad_pkg::*;
#(
    parameter int W      = 10,
    parameter int MAXCNT = 1023
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [0:W-1] req_a,
    input  logic [0:W-1] req_b,
    output logic         res_valid,
    output logic [0:W-1] res_f,
    output logic         res_sign,
    output logic         res_cout,
    output logic         res_err,
    output logic         step
);

    localparam int CW = $clog2(MAXCNT + 1);

    state_t        state;
    logic [3:0]    op_q;
    logic [0:W-1]  a_q;
    logic [0:W-1]  b_q;
    logic [CW-1:0] iter_q;

    alu_ctl_t     ctl;
    logic [0:3]   lo_a, lo_b, mi_a, mi_b, hi_a, hi_b;
    logic [0:3]   lo_f, mi_f, hi_f;
    logic         lo_co, mi_co, hi_co;
    logic [0:W-1] alu_f;
    logic         alu_sign;
    logic         alu_cout;
    logic         rsv_op;

    assign req_ready = (state == ST_IDLE);
    assign rsv_op    = (op_q[3:2] == 2'b11);

    // The top slice carries {0, A0, A0, A1}: bit 1 is the true sign and bit 0 sees
    // the W-bit carry when Y's leading bit is 0, otherwise that carry shows on COUT.
    always_comb begin
        ctl      = encode_op((state == ST_COUNT) ? OP_DEC : alu_op_t'(op_q));
        lo_a     = a_q[6:9];
        lo_b     = b_q[6:9];
        mi_a     = a_q[2:5];
        mi_b     = b_q[2:5];
        hi_a     = {1'b0, a_q[0], a_q[0], a_q[1]};
        hi_b     = {1'b0, b_q[0], b_q[0], b_q[1]};
        alu_f    = {hi_f[2:3], mi_f, lo_f};
        alu_sign = hi_f[1];
        alu_cout = ~ctl.m & (ctl.s[0] ? hi_co : hi_f[0]);
    end

    mc10181 u_lo (
        .a    (lo_a),
        .b    (lo_b),
        .s    (ctl.s),
        .m    (ctl.m),
        .cin  (ctl.cin),
        .f    (lo_f),
        .cout (lo_co)
    );

    mc10181 u_mid (
        .a    (mi_a),
        .b    (mi_b),
        .s    (ctl.s),
        .m    (ctl.m),
        .cin  (lo_co),
        .f    (mi_f),
        .cout (mi_co)
    );

    mc10181 u_top (
        .a    (hi_a),
        .b    (hi_b),
        .s    (ctl.s),
        .m    (ctl.m),
        .cin  (mi_co),
        .f    (hi_f),
        .cout (hi_co)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= 4'd0;
            a_q       <= '0;
            b_q       <= '0;
            iter_q    <= '0;
            res_valid <= 1'b0;
            res_f     <= '0;
            res_sign  <= 1'b0;
            res_cout  <= 1'b0;
            res_err   <= 1'b0;
            step      <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            step      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        a_q     <= req_a;
                        b_q     <= req_b;
                        iter_q  <= '0;
                        res_err <= 1'b0;
                        state   <= (req_op == OP_COUNT) ? ST_COUNT : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_f     <= alu_f;
                    res_sign  <= alu_sign;
                    res_cout  <= alu_cout;
                    res_err   <= rsv_op;
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_COUNT: begin
                    if (a_q[0]) begin
                        res_f     <= a_q;
                        res_sign  <= 1'b1;
                        res_cout  <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        a_q    <= alu_f;
                        step   <= 1'b1;
                        iter_q <= iter_q + 1'b1;
                        // Safety stop: report whatever the count reached.
                        if (iter_q == CW'(MAXCNT - 1)) begin
                            res_f     <= alu_f;
                            res_sign  <= alu_sign;
                            res_cout  <= 1'b0;
                            res_err   <= 1'b1;
                            res_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scad_alu_ctl.sv
// Bench for scad_alu_ctl: directed vector table, random ops against an arithmetic model,
// and a reset-during-COUNT sequence.
module tb_scad_alu_ctl;

    localparam int W      = 10;
    localparam int MAXCNT = 300;
    localparam int BOUND  = 2000;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [0:W-1] req_a;
    logic [0:W-1] req_b;
    logic         res_valid;
    logic [0:W-1] res_f;
    logic         res_sign;
    logic         res_cout;
    logic         res_err;
    logic         step;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int op;
        int a;
        int b;
        int f;
        int sign;
        int cout;
        int err;
        int steps;
        int lat;
    } vec_t;

    vec_t tbl [19];

    always #5 clk = ~clk;

    scad_alu_ctl #(.W(W), .MAXCNT(MAXCNT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_f     (res_f),
        .res_sign  (res_sign),
        .res_cout  (res_cout),
        .res_err   (res_err),
        .step      (step)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int sval(input int v);
        return (v >= 512) ? v - 1024 : v;
    endfunction

    // Reference: true signed result, wrapped to 10 bits; carry is the unsigned 10-bit carry.
    task automatic model(input int op, input int a, input int b, output vec_t r);
        int full;
        int c;
        r.op = op; r.a = a; r.b = b;
        r.cout = 0; r.err = 0; r.steps = 0; r.lat = 2;
        full = sval(a);
        case (op)
            0:  begin full = sval(a) + sval(b); r.cout = int'((a + b) > 1023); end
            1:  begin full = sval(a) - sval(b); r.cout = int'(a >= b); end
            2:  begin full = sval(a) + 1;       r.cout = int'(a == 1023); end
            3:  begin full = sval(a) - 1;       r.cout = int'(a != 0); end
            4:  full = sval(a);
            5:  full = sval(b);
            6:  full = sval(a & b);
            7:  full = sval(a | b);
            8:  full = sval(a ^ b);
            9:  full = sval(~a & 1023);
            10: full = 0;
            11: begin
                c = sval(a);
                while (c >= 0) begin
                    c--;
                    r.steps++;
                    if (r.steps == MAXCNT) begin
                        r.err = 1;
                        break;
                    end
                end
                full  = c;
                r.lat = r.err ? r.steps + 1 : r.steps + 2;
            end
            default: begin full = sval(a); r.err = 1; end
        endcase
        r.f    = full & 1023;
        r.sign = int'(full < 0);
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!req_ready && k < BOUND) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_ready"}, int'(req_ready), 1);
    endtask

    task automatic accept(input int op, input int a, input int b);
        logic [31:0] o, x, y;
        o = op; x = a; y = b;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = o[3:0];
        req_a     = x[W-1:0];
        req_b     = y[W-1:0];
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run(input vec_t v, input string tag);
        int  k, steps, first, last;
        bit  got;
        wait_ready(tag);
        accept(v.op, v.a, v.b);
        chk({tag, "_valid_early"}, int'(res_valid), 0);
        k = 0; steps = 0; first = -1; last = -1; got = 1'b0;
        while (!got && k < BOUND) begin
            @(posedge clk); #1;
            k++;
            if (step) begin
                steps++;
                if (first < 0) first = k;
                last = k;
            end
            if (res_valid) got = 1'b1;
        end
        chk({tag, "_got_valid"}, int'(got), 1);
        chk({tag, "_latency"}, k + 1, v.lat);
        chk({tag, "_f"}, int'(res_f), v.f);
        chk({tag, "_sign"}, int'(res_sign), v.sign);
        chk({tag, "_cout"}, int'(res_cout), v.cout);
        chk({tag, "_err"}, int'(res_err), v.err);
        chk({tag, "_steps"}, steps, v.steps);
        if (steps > 0) chk({tag, "_steps_contig"}, last - first + 1, steps);
        @(posedge clk); #1;
        chk({tag, "_pulse_len"}, int'(res_valid), 0);
        chk({tag, "_ready_after"}, int'(req_ready), 1);
        chk({tag, "_f_hold"}, int'(res_f), v.f);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   k, steps;

        tbl[0]  = '{0,  36,       23,       59,       0, 0, 0, 0,   2};
        tbl[1]  = '{1,  23,       36,       10'o1763, 1, 0, 0, 0,   2};
        tbl[2]  = '{1,  36,       23,       13,       0, 1, 0, 0,   2};
        tbl[3]  = '{6,  10'o1234, 10'o0707, 10'o0204, 0, 0, 0, 0,   2};
        tbl[4]  = '{7,  10'o1234, 10'o0707, 10'o1737, 1, 0, 0, 0,   2};
        tbl[5]  = '{8,  10'o1234, 10'o0707, 10'o1533, 1, 0, 0, 0,   2};
        tbl[6]  = '{9,  10'o1234, 10'o0707, 10'o0543, 0, 0, 0, 0,   2};
        tbl[7]  = '{11, 3,        0,        10'o1777, 1, 0, 0, 4,   6};
        tbl[8]  = '{11, 1019,     0,        1019,     1, 0, 0, 0,   2};
        tbl[9]  = '{0,  511,      1,        10'o1000, 0, 0, 0, 0,   2};
        tbl[10] = '{13, 10'o0123, 10'o0456, 10'o0123, 0, 0, 1, 0,   2};
        tbl[11] = '{2,  1023,     0,        0,        0, 1, 0, 0,   2};
        tbl[12] = '{3,  0,        0,        10'o1777, 1, 0, 0, 0,   2};
        tbl[13] = '{0,  512,      1023,     511,      1, 1, 0, 0,   2};
        tbl[14] = '{5,  5,        10'o1712, 10'o1712, 1, 0, 0, 0,   2};
        tbl[15] = '{10, 1023,     1023,     0,        0, 0, 0, 0,   2};
        tbl[16] = '{11, 511,      0,        211,      0, 0, 1, 300, 301};
        tbl[17] = '{4,  10'o1000, 7,        512,      1, 0, 0, 0,   2};
        tbl[18] = '{11, 0,        0,        1023,     1, 0, 0, 1,   3};

        reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = '0; req_b = '0;
        #1;
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_f", int'(res_f), 0);
        chk("rst_sign", int'(res_sign), 0);
        chk("rst_cout", int'(res_cout), 0);
        chk("rst_err", int'(res_err), 0);
        chk("rst_step", int'(step), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            model($urandom_range(0, 15), $urandom_range(0, 1023), $urandom_range(0, 1023), v);
            run(v, $sformatf("rnd%0d_op%0d", i, v.op));
        end

        // Reset while COUNT is mid-loop; results from the prior ADD must be wiped.
        model(0, 36, 23, v);
        run(v, "pre_rst");
        wait_ready("rstc");
        accept(11, 100, 0);
        k = 0; steps = 0;
        while (steps < 10 && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (step) steps++;
        end
        chk("rstc_steps_before", steps, 10);
        reset = 1'b1;
        #1;
        chk("rstc_step", int'(step), 0);
        chk("rstc_valid", int'(res_valid), 0);
        chk("rstc_f", int'(res_f), 0);
        chk("rstc_sign", int'(res_sign), 0);
        chk("rstc_cout", int'(res_cout), 0);
        chk("rstc_err", int'(res_err), 0);
        chk("rstc_ready", int'(req_ready), 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rstc_hold_valid", int'(res_valid), 0);
            chk("rstc_hold_step", int'(step), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        model(0, 1, 1, v);
        run(v, "post_rst_add");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
